// File: rtl/smart_toilet_seq.sv
// Assay sequencer for the three-inlet serpentine chip: staggers pump start-up
// so all reagents reach mix0 together, then flushes through the output valve.
module smart_toilet_seq #(
  parameter int CW      = 16,
  parameter int T_LEAD3 = 900,
  parameter int T_LEAD2 = 400,
  parameter int T_MIX   = 200,
  parameter int T_FLUSH = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       pump_soln1,
  output logic       pump_soln2,
  output logic       pump_soln3,
  output logic       valve_out,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD3 = 3'd1,
    S_LEAD2 = 3'd2,
    S_MIX   = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } st_e;

  // A zero duration is treated as one cycle, so both 0 and 1 load a zero count.
  function automatic logic [CW-1:0] load_val(input int t);
    if (t <= 1) load_val = '0;
    else        load_val = CW'(t - 1);
  endfunction

  localparam logic [CW-1:0] LD_LEAD3 = load_val(T_LEAD3);
  localparam logic [CW-1:0] LD_LEAD2 = load_val(T_LEAD2);
  localparam logic [CW-1:0] LD_MIX   = load_val(T_MIX);
  localparam logic [CW-1:0] LD_FLUSH = load_val(T_FLUSH);

  st_e           state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abf_q, abf_d;

  logic p1_q, p2_q, p3_q, vo_q, busy_q, done_q, ab_q;
  logic p1_d, p2_d, p3_d, vo_d, busy_d, done_d, ab_d;

  logic cnt_zero;
  assign cnt_zero = (cnt_q == '0);

  // State, timer, flag and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      abf_q   <= 1'b0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      p3_q    <= 1'b0;
      vo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abf_q   <= abf_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      vo_q    <= vo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ab_q    <= ab_d;
    end
  end

  // Next state; every entry into a timed state loads that state's count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - CW'(1);
    abf_d   = abf_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        abf_d = 1'b0;
        if (start && !abort) begin
          state_d = S_LEAD3;
          cnt_d   = LD_LEAD3;
        end
      end
      S_LEAD3: begin
        if (abort) begin
          state_d = S_FLUSH;
          cnt_d   = LD_FLUSH;
          abf_d   = 1'b1;
        end else if (cnt_zero) begin
          state_d = S_LEAD2;
          cnt_d   = LD_LEAD2;
        end
      end
      S_LEAD2: begin
        if (abort) begin
          state_d = S_FLUSH;
          cnt_d   = LD_FLUSH;
          abf_d   = 1'b1;
        end else if (cnt_zero) begin
          state_d = S_MIX;
          cnt_d   = LD_MIX;
        end
      end
      S_MIX: begin
        if (abort) begin
          state_d = S_FLUSH;
          cnt_d   = LD_FLUSH;
          abf_d   = 1'b1;
        end else if (cnt_zero) begin
          state_d = S_FLUSH;
          cnt_d   = LD_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt_zero) begin
          state_d = abf_q ? S_IDLE : S_DONE;
          abf_d   = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        abf_d   = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with state_q; pumps and valve come from disjoint state sets.
  always_comb begin
    p1_d   = 1'b0;
    p2_d   = 1'b0;
    p3_d   = 1'b0;
    vo_d   = 1'b0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    ab_d   = (state_q == S_FLUSH) && cnt_zero && abf_q;
    case (state_d)
      S_LEAD3: p3_d = 1'b1;
      S_LEAD2: begin
        p3_d = 1'b1;
        p2_d = 1'b1;
      end
      S_MIX: begin
        p3_d = 1'b1;
        p2_d = 1'b1;
        p1_d = 1'b1;
      end
      S_FLUSH: vo_d = 1'b1;
      default: ;
    endcase
  end

  assign pump_soln1 = p1_q;
  assign pump_soln2 = p2_q;
  assign pump_soln3 = p3_q;
  assign valve_out  = vo_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = ab_q;
  assign state      = state_q;

endmodule

// File: tb/tb_smart_toilet_seq.sv
// Table-driven bench for smart_toilet_seq with a scoreboard queue; a second
// instance with T_MIX=0 covers the zero-duration case.
module tb_smart_toilet_seq;

  logic clk = 1'b0;
  logic rst, start, abort;

  logic       p1, p2, p3, vo, bsy, dn, ab;
  logic [2:0] st;
  logic       zp1, zp2, zp3, zvo, zbsy, zdn, zab;
  logic [2:0] zst;

  always #5 clk = ~clk;

  smart_toilet_seq #(.CW(16), .T_LEAD3(4), .T_LEAD2(3), .T_MIX(2), .T_FLUSH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pump_soln1(p1), .pump_soln2(p2), .pump_soln3(p3), .valve_out(vo),
    .busy(bsy), .done(dn), .aborted(ab), .state(st)
  );

  smart_toilet_seq #(.CW(16), .T_LEAD3(4), .T_LEAD2(3), .T_MIX(0), .T_FLUSH(2)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pump_soln1(zp1), .pump_soln2(zp2), .pump_soln3(zp3), .valve_out(zvo),
    .busy(zbsy), .done(zdn), .aborted(zab), .state(zst)
  );

  typedef struct {
    logic        r;
    logic        s;
    logic        a;
    logic [9:0]  exp;
    string       nm;
  } vec_t;

  vec_t       tbl[$];
  logic [9:0] sb[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  bit         mon_en = 1'b0;

  // Expected output word {state,p1,p2,p3,valve,busy,done,aborted} for a state.
  function automatic logic [9:0] expv(input logic [2:0] s, input logic abp);
    logic [9:0] v;
    v[9:7] = s;
    v[6]   = (s == 3'd3);
    v[5]   = (s == 3'd2) || (s == 3'd3);
    v[4]   = (s == 3'd1) || (s == 3'd2) || (s == 3'd3);
    v[3]   = (s == 3'd4);
    v[2]   = (s != 3'd0);
    v[1]   = (s == 3'd5);
    v[0]   = abp;
    return v;
  endfunction

  task automatic add(input int n, input logic r, input logic s, input logic a,
                     input logic [2:0] est, input logic abp, input string nm);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.r = r; v.s = s; v.a = a; v.exp = expv(est, abp); v.nm = nm;
      tbl.push_back(v);
    end
  endtask

  // Pumps and valve must never overlap, on either instance, in any cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      n_chk++;
      if (((p1 | p2 | p3) & vo) === 1'b0 && ((zp1 | zp2 | zp3) & zvo) === 1'b0)
        n_pass++;
      else
        $display("FAIL excl t=%0t dut pumps=%b%b%b valve=%b  dut0 pumps=%b%b%b valve=%b required no overlap",
                 $time, p1, p2, p3, vo, zp1, zp2, zp3, zvo);
    end
  end

  initial begin
    logic [9:0] e, act;
    logic [2:0] zexp [12];
    rst = 1'b1; start = 1'b0; abort = 1'b0;

    add(2, 1, 0, 0, 3'd0, 0, "reset");
    // normal run
    add(1, 0, 1, 0, 3'd1, 0, "norm_lead3");
    add(3, 0, 0, 0, 3'd1, 0, "norm_lead3");
    add(3, 0, 0, 0, 3'd2, 0, "norm_lead2");
    add(2, 0, 0, 0, 3'd3, 0, "norm_mix");
    add(2, 0, 0, 0, 3'd4, 0, "norm_flush");
    add(1, 0, 0, 0, 3'd5, 0, "norm_done");
    add(1, 0, 0, 0, 3'd0, 0, "norm_idle");
    // start+abort together, abort alone, in IDLE
    add(1, 0, 1, 1, 3'd0, 0, "sa_idle");
    add(1, 0, 0, 1, 3'd0, 0, "ab_idle");
    // abort in LEAD2 (cycle 6), abort held into FLUSH
    add(1, 0, 1, 0, 3'd1, 0, "abl2_lead3");
    add(3, 0, 0, 0, 3'd1, 0, "abl2_lead3");
    add(2, 0, 0, 0, 3'd2, 0, "abl2_lead2");
    add(2, 0, 0, 1, 3'd4, 0, "abl2_flush");
    add(1, 0, 0, 0, 3'd0, 1, "abl2_pulse");
    add(1, 0, 0, 0, 3'd0, 0, "abl2_idle");
    // start held through a whole run, then abort in LEAD3
    add(1, 0, 1, 0, 3'd1, 0, "hold_lead3");
    add(3, 0, 1, 0, 3'd1, 0, "hold_lead3");
    add(3, 0, 1, 0, 3'd2, 0, "hold_lead2");
    add(2, 0, 1, 0, 3'd3, 0, "hold_mix");
    add(2, 0, 1, 0, 3'd4, 0, "hold_flush");
    add(1, 0, 1, 0, 3'd5, 0, "hold_done");
    add(1, 0, 1, 0, 3'd0, 0, "hold_idle");
    add(1, 0, 1, 0, 3'd1, 0, "hold_restart");
    add(1, 0, 0, 1, 3'd4, 0, "abl3_flush");
    add(1, 0, 0, 0, 3'd4, 0, "abl3_flush");
    add(1, 0, 0, 0, 3'd0, 1, "abl3_pulse");
    add(1, 0, 0, 0, 3'd0, 0, "abl3_idle");
    // abort in MIX
    add(1, 0, 1, 0, 3'd1, 0, "abmx_lead3");
    add(3, 0, 0, 0, 3'd1, 0, "abmx_lead3");
    add(3, 0, 0, 0, 3'd2, 0, "abmx_lead2");
    add(1, 0, 0, 0, 3'd3, 0, "abmx_mix");
    add(1, 0, 0, 1, 3'd4, 0, "abmx_flush");
    add(1, 0, 0, 0, 3'd4, 0, "abmx_flush");
    add(1, 0, 0, 0, 3'd0, 1, "abmx_pulse");
    // reset in MIX (cycle 8) overriding start/abort, then immediate restart
    add(1, 0, 1, 0, 3'd1, 0, "rst_lead3");
    add(3, 0, 0, 0, 3'd1, 0, "rst_lead3");
    add(3, 0, 0, 0, 3'd2, 0, "rst_lead2");
    add(1, 0, 0, 0, 3'd3, 0, "rst_mix");
    add(1, 1, 1, 1, 3'd0, 0, "rst_mid");
    add(1, 0, 0, 0, 3'd0, 0, "rst_quiet");
    add(1, 0, 1, 0, 3'd1, 0, "rst_restart");
    add(1, 0, 0, 1, 3'd4, 0, "rst_flush");
    add(1, 0, 0, 0, 3'd4, 0, "rst_flush");
    add(1, 0, 0, 0, 3'd0, 1, "rst_pulse");
    add(1, 0, 0, 0, 3'd0, 0, "rst_idle");

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].r; start = tbl[i].s; abort = tbl[i].a;
      sb.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      e   = sb.pop_front();
      act = {st, p1, p2, p3, vo, bsy, dn, ab};
      n_chk++;
      if (act === e) n_pass++;
      else $display("FAIL %s vec=%0d got st/p1p2p3/vo/busy/done/ab=%b required %b",
                    tbl[i].nm, i, act, e);
    end

    // zero-length MIX on the second instance
    zexp = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};
    @(negedge clk);
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n_chk++;
      if (zst === zexp[k] && zdn === (zexp[k] == 3'd5) && zp1 === (zexp[k] == 3'd3))
        n_pass++;
      else
        $display("FAIL zero_mix cyc=%0d got state=%0d done=%b p1=%b required state=%0d",
                 k + 1, zst, zdn, zp1, zexp[k]);
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
